iob_bus_split: RTL and testbench

Data-bus splitter placed directly downstream of the PicoRV32 wrapper's data bus port. It routes each native-interface transaction from one master to one of N slaves, selected by an address field. It holds the selection until the slave answers and returns that slave's response. It also synthesizes an error response for unmapped addresses and for slaves that never answer (watchdog timeout).

---
 rtl/iob_bus_split_pkg.sv | 21 ++
 rtl/iob_bus_split_watchdog.sv | 38 +++
 rtl/iob_bus_split.sv | 133 +++++++++++++
 tb/tb_iob_bus_split.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_bus_split_pkg.sv
// Shared definitions for the iob data-bus splitter.
// Packet widths, FSM state encoding and the error response data.
package iob_bus_split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam int ERR_RDATA = 0;

    function automatic int req_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int resp_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/iob_bus_split_watchdog.sv
// Response watchdog for the iob splitter: counts BUSY cycles.
// expired_o flags the enabled cycle in which the count reaches all-ones.
module iob_bus_watchdog
    import iob_bus_split_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] MAX = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == MAX - TIMEOUT_W'(1));

endmodule

// File: rtl/iob_bus_split.sv
// Native-interface data-bus splitter: one master routed to N slaves
// by an address field, with unmapped/timeout error responses.
module iob_bus_split
    import iob_bus_split_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_SLAVES  = 2,
    parameter int P_SLAVES  = ADDR_W - 1,
    parameter int TIMEOUT_W = 8,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [REQ_W-1:0]             m_req,
    output logic [RESP_W-1:0]            m_resp,
    output logic [N_SLAVES*REQ_W-1:0]    s_req,
    input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
    output logic                         err
);

    localparam int NB = $clog2(N_SLAVES);
    localparam logic [NB:0] NSL = (NB + 1)'(N_SLAVES);

    state_e          state_q, state_d;
    logic [NB-1:0]   sel_q, sel_d;
    logic            wd_clr, wd_en, wd_exp;

    logic [REQ_W-1:0]  sreq_a [N_SLAVES];
    logic [RESP_W-1:0] sresp_a [N_SLAVES];

    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     sel_in;
    logic              mapped;
    logic [REQ_W-1:0]  held;

    assign valid  = m_req[REQ_W-1];
    assign addr   = m_req[REQ_W-2 -: ADDR_W];
    assign sel_in = addr[P_SLAVES -: NB];
    assign mapped = {1'b0, sel_in} < NSL;
    assign held   = {1'b0, m_req[REQ_W-2:0]};

    for (genvar k = 0; k < N_SLAVES; k++) begin : g_pack
        assign s_req[k*REQ_W +: REQ_W] = sreq_a[k];
        assign sresp_a[k] = s_resp[k*RESP_W +: RESP_W];
    end

    iob_bus_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wd (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_exp)
    );

    always_comb begin
        logic slv_rdy;
        state_d = state_q;
        sel_d   = sel_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        err     = 1'b0;
        m_resp  = '0;
        slv_rdy = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            sreq_a[k] = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    if (mapped) begin
                        for (int k = 0; k < N_SLAVES; k++) begin
                            if (sel_in == k[NB-1:0]) sreq_a[k] = m_req;
                        end
                        sel_d   = sel_in;
                        wd_clr  = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                // A new valid here is a violation: flagged, never forwarded
                err = valid;
                for (int k = 0; k < N_SLAVES; k++) begin
                    if (sel_q == k[NB-1:0]) begin
                        sreq_a[k] = held;
                        m_resp    = sresp_a[k];
                        slv_rdy   = sresp_a[k][0];
                    end
                end
                if (slv_rdy) begin
                    state_d = IDLE;
                end else begin
                    wd_en = 1'b1;
                    if (wd_exp) state_d = ERR;
                end
            end
            ERR: begin
                m_resp  = {DATA_W'(ERR_RDATA), 1'b1};
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs must drop the moment reset asserts, not at the next edge
        if (!resetn) begin
            err    = 1'b0;
            m_resp = '0;
            for (int k = 0; k < N_SLAVES; k++) begin
                sreq_a[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_iob_bus_split.sv
// Bench for iob_bus_split: transaction table, corner-case sequences
// and randomized traffic against a transaction-level reference model.
module tb_iob_bus_split;

    localparam int RQ = 69;
    localparam int RS = 33;
    localparam int T  = 4;
    localparam int TO = (1 << T);

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [RQ-1:0]   m_req_a, m_req_b;
    logic [RS-1:0]   m_resp_a, m_resp_b;
    logic [2*RQ-1:0] s_req_a;
    logic [2*RS-1:0] s_resp_a;
    logic [3*RQ-1:0] s_req_b;
    logic [3*RS-1:0] s_resp_b;
    logic            err_a, err_b;

    iob_bus_split #(
        .ADDR_W(32), .DATA_W(32), .N_SLAVES(2),
        .P_SLAVES(31), .TIMEOUT_W(T)
    ) dut_a (
        .clk(clk), .resetn(resetn), .m_req(m_req_a), .m_resp(m_resp_a),
        .s_req(s_req_a), .s_resp(s_resp_a), .err(err_a)
    );

    iob_bus_split #(
        .ADDR_W(32), .DATA_W(32), .N_SLAVES(3),
        .P_SLAVES(31), .TIMEOUT_W(T)
    ) dut_b (
        .clk(clk), .resetn(resetn), .m_req(m_req_b), .m_resp(m_resp_b),
        .s_req(s_req_b), .s_resp(s_resp_b), .err(err_b)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dly;
        logic [31:0] rdata;
        int          exp_slave;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [RQ-1:0] mk_req(input logic v,
        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        return {v, a, wd, ws};
    endfunction

    task automatic set_in(input int d, input logic [RQ-1:0] req,
                          input int slv, input logic [RS-1:0] rsp);
        m_req_a = '0; m_req_b = '0; s_resp_a = '0; s_resp_b = '0;
        if (d == 0) begin
            m_req_a = req;
            if (slv >= 0) s_resp_a[slv*RS +: RS] = rsp;
        end else begin
            m_req_b = req;
            if (slv >= 0) s_resp_b[slv*RS +: RS] = rsp;
        end
    endtask

    function automatic logic [RQ-1:0] sreq_of(input int d, input int k);
        return (d == 0) ? s_req_a[k*RQ +: RQ] : s_req_b[k*RQ +: RQ];
    endfunction

    function automatic logic [RS-1:0] mresp_of(input int d);
        return (d == 0) ? m_resp_a : m_resp_b;
    endfunction

    function automatic logic err_of(input int d);
        return (d == 0) ? err_a : err_b;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [RQ-1:0] req, held, exp_t;
        bit done, fwd_bad, other_bad, early_err;
        int nsl;
        req  = mk_req(1'b1, v.addr, v.wdata, v.wstrb);
        held = {1'b0, req[RQ-2:0]};
        nsl  = (v.d == 0) ? 2 : 3;
        done = 0; fwd_bad = 0; other_bad = 0; early_err = 0;
        for (int c = 0; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            set_in(v.d, (c == 0) ? req : held,
                   (v.exp_slave >= 0 && c == v.dly) ? v.exp_slave : -1,
                   {v.rdata, 1'b1});
            @(negedge clk);
            exp_t = (c == 0) ? req :
                    (c == v.exp_lat && v.exp_err) ? '0 : held;
            for (int k = 0; k < nsl; k++) begin
                if (k != v.exp_slave) begin
                    if (sreq_of(v.d, k) !== '0) other_bad = 1;
                end else if (sreq_of(v.d, k) !== exp_t) begin
                    fwd_bad = 1;
                end
            end
            if (mresp_of(v.d)[0] === 1'b1) begin
                done = 1;
                check({tag, "_lat"}, c, v.exp_lat);
                check({tag, "_rdata"}, mresp_of(v.d)[RS-1:1], v.exp_rdata);
                check({tag, "_err"}, err_of(v.d), v.exp_err);
            end else if (err_of(v.d) !== 1'b0) begin
                early_err = 1;
            end
        end
        check({tag, "_ready_seen"}, done, 1);
        check({tag, "_fwd"}, fwd_bad, 0);
        check({tag, "_others_zero"}, other_bad, 0);
        check({tag, "_no_early_err"}, early_err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[11];
        vec_t vr;
        logic [RQ-1:0] rq, hd;

        vecs[0]  = '{0, 32'h0000_0010, 32'h0, 4'h0, 3, 32'h1234_5678,
                     0, 3, 32'h1234_5678, 1'b0};
        vecs[1]  = '{0, 32'h8000_0004, 32'hA5A5_A5A5, 4'hF, 2, 32'h0000_DEAD,
                     1, 2, 32'h0000_DEAD, 1'b0};
        vecs[2]  = '{0, 32'h7FFF_FFFC, 32'h1111_2222, 4'h3, 1, 32'hCAFE_0001,
                     0, 1, 32'hCAFE_0001, 1'b0};
        vecs[3]  = '{0, 32'h0000_0040, 32'h0, 4'h0, 99, 32'hFFFF_FFFF,
                     0, TO, 32'h0, 1'b1};
        vecs[4]  = '{0, 32'h8000_0000, 32'h0, 4'h0, TO - 1, 32'h0BAD_F00D,
                     1, TO - 1, 32'h0BAD_F00D, 1'b0};
        vecs[5]  = '{1, 32'hC000_0000, 32'h5555_5555, 4'h1, 0, 32'h0,
                     -1, 1, 32'h0, 1'b1};
        vecs[6]  = '{1, 32'h8000_0020, 32'h0, 4'h0, 2, 32'h2222_3333,
                     2, 2, 32'h2222_3333, 1'b0};
        vecs[7]  = '{1, 32'h4000_0000, 32'h9, 4'hC, 4, 32'h4444_5555,
                     1, 4, 32'h4444_5555, 1'b0};
        vecs[8]  = '{1, 32'hFFFF_FFFF, 32'h0, 4'h0, 0, 32'h0,
                     -1, 1, 32'h0, 1'b1};
        vecs[9]  = '{0, 32'h8000_0010, 32'h7, 4'hF, TO, 32'h6666_7777,
                     1, TO, 32'h0, 1'b1};
        vecs[10] = '{1, 32'h0000_0000, 32'h0, 4'h0, 99, 32'h0,
                     0, TO, 32'h0, 1'b1};

        // reset state, with a live request on the master port
        resetn = 1'b0;
        set_in(0, mk_req(1'b1, 32'h0, 32'h1, 4'hF), 0, {32'h1, 1'b1});
        #12;
        check("rst_sreq_a", s_req_a, 0);
        check("rst_mresp_a", m_resp_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_sreq_b", s_req_b, 0);
        set_in(0, '0, -1, '0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // late slave ready after a timeout never reaches the master
        rq = mk_req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        hd = {1'b0, rq[RQ-2:0]};
        for (int c = 0; c <= TO + 3; c++) begin
            @(posedge clk); #1;
            set_in(0, (c == 0) ? rq : (c <= TO) ? hd : '0,
                   (c == TO + 3) ? 0 : -1, {32'hBEEF, 1'b1});
            @(negedge clk);
            if (c == TO) begin
                check("late_timeout_resp", m_resp_a, {32'h0, 1'b1});
                check("late_timeout_err", err_a, 1);
            end
            if (c == TO + 3) begin
                check("late_ready_resp", m_resp_a, 0);
                check("late_ready_err", err_a, 0);
            end
        end

        // asynchronous reset in the middle of a BUSY transaction
        rq = mk_req(1'b1, 32'h8000_0000, 32'h0, 4'h0);
        hd = {1'b0, rq[RQ-2:0]};
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk); #1;
            set_in(0, (c == 0) ? rq : hd, (c == 2) ? 1 : -1,
                   {32'h77, 1'b0});
        end
        @(negedge clk);
        check("busy_passthru", m_resp_a, {32'h77, 1'b0});
        #1 resetn = 1'b0;
        #1;
        check("midrst_sreq", s_req_a, 0);
        check("midrst_mresp", m_resp_a, 0);
        set_in(0, rq, 1, {32'h77, 1'b1});
        #1;
        check("midrst_valid_sreq", s_req_a, 0);
        check("midrst_valid_mresp", m_resp_a, 0);
        @(negedge clk);
        set_in(0, '0, -1, '0);
        resetn = 1'b1;
        vr = '{0, 32'h8000_0100, 32'h0, 4'h0, 2, 32'h1357_9BDF,
               1, 2, 32'h1357_9BDF, 1'b0};
        run_vec(vr, "post_rst");

        // valid during BUSY: flagged, not forwarded, transfer completes
        rq = mk_req(1'b1, 32'h8000_0008, 32'h0, 4'h0);
        hd = {1'b0, rq[RQ-2:0]};
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            set_in(0, (c == 0 || c == 1) ? rq : hd, (c == 3) ? 1 : -1,
                   {32'hCAFE, 1'b1});
            @(negedge clk);
            if (c == 1) begin
                check("viol_err", err_a, 1);
                check("viol_sreq", s_req_a, {hd, {RQ{1'b0}}});
            end
            if (c == 2) check("viol_err_once", err_a, 0);
            if (c == 3) begin
                check("viol_done_resp", m_resp_a, {32'hCAFE, 1'b1});
                check("viol_done_err", err_a, 0);
            end
        end

        // randomized traffic on the 3-slave instance
        begin
            int mode, tgt, age, sel;
            logic v;
            logic [RQ-1:0]   cur, req;
            logic [3*RQ-1:0] e_sreq;
            logic [RS-1:0]   e_resp;
            logic            e_err;
            mode = 0; tgt = 0; age = 0; cur = '0;
            for (int n = 0; n < 500; n++) begin
                @(posedge clk); #1;
                if (mode == 0) begin
                    cur = {1'b0, 32'($urandom), 32'($urandom),
                           4'($urandom)};
                    v = ($urandom_range(0, 2) != 0);
                end else begin
                    v = ($urandom_range(0, 15) == 0);
                end
                req = {v, cur[RQ-2:0]};
                m_req_a = '0; s_resp_a = '0;
                m_req_b = req;
                for (int k = 0; k < 3; k++) begin
                    s_resp_b[k*RS +: RS] = {32'($urandom),
                                            ($urandom_range(0, 7) == 0)};
                end
                e_sreq = '0; e_resp = '0; e_err = 1'b0;
                sel = int'(req[RQ-2 -: 2]);
                if (mode == 0) begin
                    if (v && sel < 3) e_sreq[sel*RQ +: RQ] = req;
                end else if (mode == 1) begin
                    e_sreq[tgt*RQ +: RQ] = {1'b0, req[RQ-2:0]};
                    e_resp = s_resp_b[tgt*RS +: RS];
                    e_err  = v;
                end else begin
                    e_resp = {32'h0, 1'b1};
                    e_err  = 1'b1;
                end
                @(negedge clk);
                check($sformatf("rnd%0d_sreq", n), s_req_b, e_sreq);
                check($sformatf("rnd%0d_mresp", n), m_resp_b, e_resp);
                check($sformatf("rnd%0d_err", n), err_b, e_err);
                // age = cycles elapsed since the accepted valid
                if (mode == 0) begin
                    if (v) begin
                        if (sel < 3) begin
                            mode = 1; tgt = sel; age = 1;
                        end else begin
                            mode = 2;
                        end
                    end
                end else if (mode == 1) begin
                    if (s_resp_b[tgt*RS] == 1'b1) mode = 0;
                    else if (age == TO - 1) mode = 2;
                    else age++;
                end else begin
                    mode = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
